// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared types, constants and hand arithmetic for the blackjack datapath
package blackjack_pkg;
  typedef enum logic [1:0] {TGT_P1, TGT_P2, TGT_D, TGT_NONE} target_t;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_ADD, S_DONE} state_t;
  typedef logic [3:0] card_t;
  typedef logic [4:0] hand_t;
  localparam hand_t HAND_MAX = 5'd31;
  localparam hand_t ACE_HIGH = 5'd11;

  function automatic hand_t sat(input logic [5:0] v);
    return v > 6'(HAND_MAX) ? HAND_MAX : v[4:0];
  endfunction

  function automatic card_t clamp_card(input card_t c);
    return c == 4'd0 ? 4'd1 : c > 4'd10 ? 4'd10 : c;
  endfunction

  // A hand with low==0 has never held an ace, so the first ace splits it into 11-high / 1-low.
  function automatic logic [9:0] hand_add(input hand_t hi, input hand_t lo, input card_t c);
    logic first_ace;
    hand_t h, l;
    first_ace = lo == 5'd0 && c == 4'd1;
    h = sat(6'(hi) + (first_ace ? 6'(ACE_HIGH) : 6'(c)));
    l = lo != 5'd0 ? sat(6'(lo) + 6'(c)) : first_ace ? sat(6'(hi) + 6'd1) : 5'd0;
    return {h, l};
  endfunction
endpackage

// File: rtl/card_lfsr.sv
// card_lfsr: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11) used as card entropy
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);
  // shift right every cycle, folding the ejected bit into the tap positions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SEED;
    else state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals pseudo-random cards into P1/P2/dealer high/low totals; DEALER_TEST_CARD_EN adds test-card injection
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deal_req,
  input  logic [1:0] deal_target,
  input  logic       clear_hands,
`ifdef DEALER_TEST_CARD_EN
  input  logic       test_card_vld,
  input  logic [3:0] test_card,
`endif
  output logic       cardsUpdated,
  output logic [3:0] last_card,
  output logic [4:0] p1_high,
  output logic [4:0] p1_low,
  output logic [4:0] p2_high,
  output logic [4:0] p2_low,
  output logic [4:0] d_high,
  output logic [4:0] d_low
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t        state, state_nxt;
  target_t       tgt;
  card_t         card, raw, draw_card;
  logic [TW-1:0] tries;
  logic          forced, raw_ok, draw_hit, unused_lfsr;
  logic [15:0]   lfsr;
  hand_t         hi [3];
  hand_t         lo [3];

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .state(lfsr));

  assign raw         = lfsr[3:0];
  assign unused_lfsr = ^lfsr[15:4];
  assign forced      = tries == TW'(MAX_TRIES);
  assign raw_ok      = raw != 4'd0 && raw <= 4'd13;
`ifdef DEALER_TEST_CARD_EN
  assign draw_hit  = test_card_vld || forced || raw_ok;
  assign draw_card = test_card_vld ? clamp_card(test_card) : forced ? 4'd10 : clamp_card(raw);
`else
  assign draw_hit  = forced || raw_ok;
  assign draw_card = forced ? 4'd10 : clamp_card(raw);
`endif

  assign p1_high = hi[0];
  assign p1_low  = lo[0];
  assign p2_high = hi[1];
  assign p2_low  = lo[1];
  assign d_high  = hi[2];
  assign d_low   = lo[2];

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;

  // next state: clear_hands aborts from anywhere; the reserved target never leaves IDLE
  always_comb begin
    cardsUpdated = state == S_IDLE;
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = deal_req && target_t'(deal_target) != TGT_NONE ? S_DRAW : S_IDLE;
      S_DRAW:  state_nxt = draw_hit ? S_ADD : S_DRAW;
      S_ADD:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (clear_hands) state_nxt = S_IDLE;
  end

  // datapath: latch target while idle, capture the drawn card, then fold it into the selected hand
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tgt       <= TGT_P1;
      card      <= '0;
      tries     <= '0;
      last_card <= '0;
      hi        <= '{default: '0};
      lo        <= '{default: '0};
    end else if (clear_hands) begin
      last_card <= '0;
      hi        <= '{default: '0};
      lo        <= '{default: '0};
    end else begin
      if (state == S_IDLE) begin
        tgt   <= target_t'(deal_target);
        tries <= '0;
      end
      if (state == S_DRAW) begin
        card  <= draw_card;
        tries <= tries + TW'(1);
      end
      if (state == S_ADD) begin
        {hi[tgt], lo[tgt]} <= hand_add(hi[tgt], lo[tgt], card);
        last_card          <= card;
      end
    end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized self-checking bench for card_dealer against a rule-level hand model
module tb_card_dealer;
  localparam int MAX_TRIES = 8;
  logic       clk = 0, rst_n = 0, deal_req = 0, clear_hands = 0, test_card_vld = 0;
  logic [1:0] deal_target = 0;
  logic [3:0] test_card = 0;
  logic       cardsUpdated;
  logic [3:0] last_card;
  logic [4:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
  logic [15:0] mdl_lfsr;
  int mh[3], ml[3], mlast;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  card_dealer dut (
    .clk(clk), .rst_n(rst_n), .deal_req(deal_req), .deal_target(deal_target),
    .clear_hands(clear_hands),
`ifdef DEALER_TEST_CARD_EN
    .test_card_vld(test_card_vld), .test_card(test_card),
`endif
    .cardsUpdated(cardsUpdated), .last_card(last_card),
    .p1_high(p1_high), .p1_low(p1_low), .p2_high(p2_high), .p2_low(p2_low),
    .d_high(d_high), .d_low(d_low)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // entropy source: the published Galois polynomial, free-running from the seed
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mdl_lfsr <= 16'hACE1;
    else mdl_lfsr <= lfsr_step(mdl_lfsr);

  // rejection sampling seen from outside: card and cycles until cardsUpdated returns
  function automatic void predict(input logic [15:0] s, output int c, output int lat);
    c = 10;
    lat = MAX_TRIES + 3;
    for (int k = 0; k < MAX_TRIES; k++) begin
      if (s[3:0] >= 1 && s[3:0] <= 13) begin
        c = s[3:0] > 10 ? 10 : int'(s[3:0]);
        lat = k + 3;
        return;
      end
      s = lfsr_step(s);
    end
  endfunction

  function automatic int min31(input int v);
    return v > 31 ? 31 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic mdl_add(input int t, input int c);
    if (ml[t] != 0) begin
      mh[t] = min31(mh[t] + c);
      ml[t] = min31(ml[t] + c);
    end else if (c == 1) begin
      ml[t] = min31(mh[t] + 1);
      mh[t] = min31(mh[t] + 11);
    end else mh[t] = min31(mh[t] + c);
    mlast = c;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      ml[i] = 0;
    end
    mlast = 0;
  endtask

  task automatic check_hands(input string tag);
    chk({tag, ".p1_high"}, p1_high, mh[0]);
    chk({tag, ".p1_low"}, p1_low, ml[0]);
    chk({tag, ".p2_high"}, p2_high, mh[1]);
    chk({tag, ".p2_low"}, p2_low, ml[1]);
    chk({tag, ".d_high"}, d_high, mh[2]);
    chk({tag, ".d_low"}, d_low, ml[2]);
    chk({tag, ".last_card"}, last_card, mlast);
  endtask

  // one accepted deal; tc < 0 means draw from the LFSR
  task automatic deal(input int t, input int tc, input string tag);
    int c, lat, n;
    @(negedge clk);
    deal_req = 1;
    deal_target = 2'(t);
    test_card_vld = tc >= 0;
    test_card = tc >= 0 ? 4'(tc) : 4'd0;
    @(posedge clk);
    #1;
    deal_req = 0;
    predict(mdl_lfsr, c, lat);
`ifdef DEALER_TEST_CARD_EN
    if (tc >= 0) begin
      c = tc == 0 ? 1 : tc > 10 ? 10 : tc;
      lat = 3;
    end
`endif
    chk({tag, ".busy"}, cardsUpdated, 0);
    n = 0;
    while (!cardsUpdated && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    test_card_vld = 0;
    chk({tag, ".latency"}, n, lat);
    mdl_add(t, c);
    chk({tag, ".card_range"}, last_card >= 1 && last_card <= 10, 1);
    check_hands(tag);
  endtask

  task automatic clear_now(input string tag);
    @(negedge clk);
    clear_hands = 1;
    @(posedge clk);
    #1;
    clear_hands = 0;
    mdl_clear();
    chk({tag, ".cu"}, cardsUpdated, 1);
    check_hands(tag);
  endtask

  initial begin
    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.cu", cardsUpdated, 1);
    check_hands("reset");
    @(negedge clk);
    rst_n = 1;

    deal(0, 7, "p1_7");
    deal(0, 9, "p1_9");
    deal(2, 6, "d_6");
    deal(2, 1, "d_ace1");
    deal(2, 1, "d_ace2");
    deal(2, 10, "d_10");
    deal(1, 10, "p2_10a");
    deal(1, 10, "p2_10b");
    deal(1, 5, "p2_5");
    deal(1, 10, "p2_sat");
    deal(0, 15, "p1_clamp_hi");
    deal(0, 0, "p1_clamp_lo");
`ifdef DEALER_TEST_CARD_EN
    chk("lit.d_high", d_high, 28);
    chk("lit.d_low", d_low, 18);
    chk("lit.p2_high", p2_high, 31);
    chk("lit.p1_high", p1_high, 31);
    chk("lit.p1_low", p1_low, 27);
`endif

    // reserved target: request ignored
    @(negedge clk);
    deal_req = 1;
    deal_target = 2'd3;
    @(negedge clk);
    deal_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("tgt3.cu", cardsUpdated, 1);
    end
    check_hands("tgt3");

    // clear_hands with deal_req while drawing: abort, nothing added
    @(negedge clk);
    deal_req = 1;
    deal_target = 2'd0;
    test_card_vld = 1;
    test_card = 4'd5;
    @(negedge clk);
    clear_hands = 1;
    @(posedge clk);
    #1;
    clear_hands = 0;
    deal_req = 0;
    test_card_vld = 0;
    mdl_clear();
    chk("clr_draw.cu", cardsUpdated, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("clr_draw.cu_later", cardsUpdated, 1);
    check_hands("clr_draw");

    // simultaneous deal_req + clear_hands in IDLE: request dropped
    @(negedge clk);
    deal_req = 1;
    deal_target = 2'd2;
    clear_hands = 1;
    @(negedge clk);
    deal_req = 0;
    clear_hands = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_idle.cu", cardsUpdated, 1);
    check_hands("clr_idle");

    // LFSR-only random deals
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) clear_now("rnd_clr");
      deal(int'($urandom_range(0, 2)), -1, "rnd");
    end

    // asynchronous reset in the middle of a deal
    deal(1, -1, "pre_rst");
    @(negedge clk);
    deal_req = 1;
    deal_target = 2'd1;
    @(negedge clk);
    deal_req = 0;
    #2;
    rst_n = 0;
    #1;
    mdl_clear();
    chk("mid_rst.cu", cardsUpdated, 1);
    check_hands("mid_rst");
    @(negedge clk);
    rst_n = 1;
    deal(2, -1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
